// File: rtl/vga_scan_out.sv
// 640x480@60 raster generator that drains a FWFT pixel FIFO, one pop per active pixel.
// An empty FIFO during active video outputs black and sets a sticky underflow flag. The raster never stalls.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [23:0] fifo_data_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_en_o,
  output logic [23:0] rgb_o,
  output logic        hsync_n_o,
  output logic        vsync_n_o,
  output logic        blank_n_o,
  output logic        frame_start_o,
  output logic        underflow_o
);

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] H_HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] V_VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [23:0] rgb_q;
  logic        hsync_n_q, vsync_n_q, blank_n_q, frame_start_q, underflow_q;

  logic run, active, in_hs, in_vs, pop, h_last, v_last;

  always_comb begin
    run    = (state_q == RUN);
    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    in_hs  = (h_cnt_q >= H_HS_LO) && (h_cnt_q < H_HS_HI);
    in_vs  = (v_cnt_q >= V_VS_LO) && (v_cnt_q < V_VS_HI);
    pop    = run && active && !fifo_empty_i;
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
  end

  // Counters stay parked at the origin until the first non-empty FIFO is seen
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (run) begin
      h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d = !h_last ? v_cnt_q : (v_last ? 10'd0 : v_cnt_q + 10'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (!fifo_empty_i) state_q <= RUN;
        RUN:  state_q <= RUN;
      endcase
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= pop ? fifo_data_i : 24'h000000;
      blank_n_q     <= run && active;
      hsync_n_q     <= !(run && in_hs);
      vsync_n_q     <= !(run && in_vs);
      frame_start_q <= run && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      underflow_q   <= underflow_q || (run && active && fifo_empty_i);
    end
  end

  assign fifo_rd_en_o  = pop;
  assign rgb_o         = rgb_q;
  assign hsync_n_o     = hsync_n_q;
  assign vsync_n_o     = vsync_n_q;
  assign blank_n_o     = blank_n_q;
  assign frame_start_o = frame_start_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out on a shrunken raster. The reference model derives the
// raster position from the count of cycles since the block started running.
module tb_vga_scan_out;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 4;
  localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [23:0] rgb;
  logic        hsync_n, vsync_n, blank_n, frame_start, underflow;

  always #5 clk = ~clk;

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en), .rgb_o(rgb), .hsync_n_o(hsync_n), .vsync_n_o(vsync_n),
    .blank_n_o(blank_n), .frame_start_o(frame_start), .underflow_o(underflow)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic bl, hs, vs, fs, uf;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [23:0] fifo_q[$];
  logic [23:0] next_pix;
  int          total = 0, bad = 0;
  bit          refill, rand_data, force_empty, last_rd;
  int          empty_pct;
  bit          m_run, m_uf;
  int          m_p;
  bit          pop_chk, pop_armed;
  int          pops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t got=%0h want=%0h", name, $time, act, req);
    end
  endtask

  function automatic int mh();
    return m_p % HT;
  endfunction
  function automatic int mv();
    return (m_p / HT) % VT;
  endfunction

  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("rgb", {8'h0, rgb}, {8'h0, mon_e.rgb});
      chk("blank_n", {31'h0, blank_n}, {31'h0, mon_e.bl});
      chk("hsync_n", {31'h0, hsync_n}, {31'h0, mon_e.hs});
      chk("vsync_n", {31'h0, vsync_n}, {31'h0, mon_e.vs});
      chk("frame_start", {31'h0, frame_start}, {31'h0, mon_e.fs});
      chk("underflow", {31'h0, underflow}, {31'h0, mon_e.uf});
    end
  end

  task automatic step();
    bit   fe, act, exp_rd;
    int   h, v;
    exp_t e;
    @(negedge clk);
    if (last_rd) void'(fifo_q.pop_front());
    if (refill)
      while (fifo_q.size() < 4) begin
        fifo_q.push_back(rand_data ? 24'($urandom) : next_pix);
        next_pix++;
      end
    fe = force_empty || (fifo_q.size() == 0) || ($urandom_range(99) < empty_pct);
    fifo_empty = fe;
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 24'hBAD0BA;
    #1;
    if (!m_run) begin
      exp_rd = 1'b0;
      e = '{rgb: 24'h0, bl: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, uf: m_uf};
      sb.push_back(e);
      if (!fe) begin
        m_run = 1'b1;
        m_p   = 0;
      end
    end else begin
      h = mh();
      v = mv();
      if (m_p % FT == 0) begin
        if (pop_chk && pop_armed) chk("pops_per_frame", pops, HA * VA);
        pops      = 0;
        pop_armed = pop_chk;
      end
      act    = (h < HA) && (v < VA);
      exp_rd = act && !fe;
      if (act && fe) m_uf = 1'b1;
      e.rgb = exp_rd ? fifo_data : 24'h0;
      e.bl  = act;
      e.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e.fs  = (m_p % FT == 0);
      e.uf  = m_uf;
      sb.push_back(e);
      if (fifo_rd_en) pops++;
      m_p++;
    end
    chk("rd_en", {31'h0, fifo_rd_en}, {31'h0, exp_rd});
    last_rd = fifo_rd_en;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rgb", {8'h0, rgb}, 32'h0);
    chk("rst_blank_n", {31'h0, blank_n}, 32'h0);
    chk("rst_hsync_n", {31'h0, hsync_n}, 32'h1);
    chk("rst_vsync_n", {31'h0, vsync_n}, 32'h1);
    chk("rst_frame_start", {31'h0, frame_start}, 32'h0);
    chk("rst_underflow", {31'h0, underflow}, 32'h0);
    chk("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
  endtask

  // Asserts reset between clock edges; inputs held empty so the first
  // edge after release is an idle one.
  task automatic do_reset(input int n);
    @(negedge clk);
    if (last_rd) void'(fifo_q.pop_front());
    #2 rst_n = 1'b0;
    fifo_empty = 1'b1;
    #1 chk_reset_vals();
    sb.delete();
    m_run = 1'b0; m_uf = 1'b0; last_rd = 1'b0; pop_armed = 1'b0;
    repeat (n) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic seek(input string name, input int hh, input int vv);
    for (int i = 0; i < 2 * FT && !(m_run && mh() == hh && mv() == vv); i++) step();
    chk(name, {31'h0, (m_run && mh() == hh && mv() == vv)}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    refill = 0; rand_data = 0; force_empty = 0; last_rd = 0; empty_pct = 0;
    m_run = 0; m_uf = 0; m_p = 0; pop_chk = 0; pop_armed = 0; pops = 0; next_pix = '0;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals();
    #1 rst_n = 1'b1;

    // Empty FIFO: block must idle with outputs at reset values
    force_empty = 1;
    repeat (100) step();

    // Incrementing pattern, never empty: three full frames with pop counts
    force_empty = 0; refill = 1; pop_chk = 1;
    repeat (3 * FT + 5) step();
    pop_chk = 0;

    // Five-pixel starvation mid active line
    seek("seek_uf_pos", 5, 3);
    force_empty = 1;
    repeat (5) step();
    force_empty = 0;
    repeat (2 * FT) step();

    // Random data with random empty cycles
    rand_data = 1; empty_pct = 10;
    repeat (FT) step();
    empty_pct = 0;

    // Mid-frame reset, idle while empty, then restart from leftover contents
    seek("seek_rst_pos", 7, 5);
    do_reset(3);
    force_empty = 1;
    repeat (20) step();
    force_empty = 0;
    repeat (100) step();

    // Drain the FIFO, then refill only once vertical blanking is reached
    refill = 0;
    for (int i = 0; i < 2 * FT && fifo_q.size() > 0; i++) step();
    chk("drain", fifo_q.size(), 0);
    for (int i = 0; i < 2 * FT && !(mv() >= VA); i++) step();
    chk("seek_vblank", {31'h0, (mv() >= VA)}, 32'h1);
    refill = 1;
    repeat (FT) step();

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Pixel-scan output stage of the VGA path. Sits directly downstream of the FIFO that `display_pane` fills. Generates 640x480@60 Hz raster timing on the pixel clock and pops one 24-bit pixel from a first-word-fall-through FIFO per active pixel. Drives registered RGB, sync and blanking to the DAC/connector pins. On FIFO underflow it substitutes black and flags the condition rather than slipping the raster.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk`  in  1  pixel clock (25 MHz nominal), all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `fifo_data`  in  24  head-of-FIFO pixel {R[23:16],G[15:8],B[7:0]}, valid whenever `fifo_empty`=0 (FWFT)
- `fifo_empty`  in  1  FIFO empty
- `fifo_rd_en`  out  1  pop strobe, combinational; head advances at the same edge
- `rgb`  out  24  registered pixel output
- `hsync_n`  out  1  registered horizontal sync, active-low
- `vsync_n`  out  1  registered vertical sync, active-low
- `blank_n`  out  1  registered; 1 during the active region
- `frame_start`  out  1  registered one-cycle pulse aligned with the first active pixel of each frame
- `underflow`  out  1  sticky; set on any active pixel with FIFO empty, cleared only by reset

## Operation
- Counters: `h_cnt` 0..H_TOTAL-1 (H_TOTAL=800), `v_cnt` 0..V_TOTAL-1 (V_TOTAL=525). Both are 10-bit unsigned. `h_cnt` wraps to 0 and increments `v_cnt`. `v_cnt` wraps to 0 after V_TOTAL-1. Totals are sums of the parameters.
- Region decode, on counters:
  - active = `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE
  - hsync = H_ACTIVE+H_FP <= `h_cnt` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vsync = V_ACTIVE+V_FP <= `v_cnt` < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
- State machine, 2 states:
  - IDLE: counters held at 0. `fifo_rd_en`=0. Outputs at reset values. Go to RUN on the first cycle with `fifo_empty`=0.
  - RUN: counters free-run. Never returns to IDLE except via reset.
- `fifo_rd_en` = RUN & active & ~`fifo_empty`.
- Next `rgb`:
  - `fifo_data` if RUN & active & ~`fifo_empty`
  - 24'h000000 otherwise, including blanking and underflow
- Underflow (RUN & active & `fifo_empty`): outputs black, no pop, raster position unaffected, `underflow` set next edge. The missing pixel is not made up; the upstream slip persists until reset.
- Full FIFO is irrelevant to this block. Pops never exceed one per cycle.

## Timing
- Reset values, all asynchronous on `rst_n`=0: state IDLE, `h_cnt`=`v_cnt`=0, `rgb`=0, `hsync_n`=1, `vsync_n`=1, `blank_n`=0, `frame_start`=0, `underflow`=0. `fifo_rd_en`=0 while in reset and in IDLE.
- IDLE->RUN: the edge at which `fifo_empty`=0 is sampled moves state to RUN with counters still 0. The first pop occurs in the following cycle (h=0,v=0).
- Pipeline latency: 1 cycle. `rgb`, `blank_n`, `hsync_n`, `vsync_n` and `frame_start` reflect the counter values of the previous cycle. All five are mutually aligned.
- The pixel popped at cycle N appears on `rgb` at cycle N+1 with `blank_n`=1.
- Per frame: exactly 307200 pops when no underflow.
- Per line:
  - `blank_n` high for 640 cycles, low for 160 cycles
  - `hsync_n` low for 96 cycles, starting 16 cycles after `blank_n` falls
- Per frame: `vsync_n` low for 2 full lines (1600 cycles), starting 10 lines after the last active line.
- Reset deasserted mid-frame: the raster restarts from IDLE. Leftover FIFO contents are not flushed by this block.

## Test plan
- Reset then hold `fifo_empty`=1 for 1000 cycles -> `fifo_rd_en`=0 throughout, `hsync_n`=`vsync_n`=1, `blank_n`=0, `rgb`=0.
- FIFO model preloaded with an incrementing pattern, `fifo_empty` drops -> first `rd_en` one cycle later; `rgb`=000000,000001,... with `blank_n`=1; `frame_start` pulses once together with `rgb`=000000.
- Run 2 full frames with an always-non-empty FIFO -> 307200 pops per frame; period is 800 clocks for `hsync_n` and 420000 clocks for `vsync_n`; widths 96 and 1600 cycles; `underflow`=0.
- Force `fifo_empty`=1 for 5 cycles mid-line 100 -> `rgb`=0 with `blank_n`=1 for those 5 pixels; no pops; `underflow`=1 and stays 1; sync timing unchanged.
- Assert `rst_n`=0 at line 300, pixel 200, for 3 cycles -> outputs return to reset values immediately (asynchronously); after release, block waits in IDLE for non-empty, then restarts at h=0,v=0.
- Fill FIFO during vertical blanking only -> no pops while `blank_n` is low; the first pop is at the next active pixel.
